// File: rtl/bit_string_printer.sv
// Collects WIDTH ASCII '0'/'1' digits into a word and prints it back (forward or reversed, optional CR LF).
// Optional build macro BIT_STRING_ECHO_EN echoes each accepted digit/backspace while collecting.
module bit_string_printer #(
    parameter int WIDTH     = 8,
    parameter int TERM_CRLF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             new_rx_data,
    input  logic             tx_busy,
    input  logic             rev_mode,
    output logic [7:0]       tx_data,
    output logic             new_tx_data,
    output logic [WIDTH-1:0] word_q,
    output logic             word_valid,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH + 3);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CR_IDX     = CW'(WIDTH);
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1 + 2 * TERM_CRLF);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_full;
    logic             mode_rev;
    logic             is_digit;
    logic             is_bksp;
    logic             word_done;
    logic             digit_bit;
    logic [7:0]       char_byte;

`ifdef BIT_STRING_ECHO_EN
    logic       echo_pend;
    logic [7:0] echo_char;
    logic       echo_gap;
`endif

    always_comb begin
        is_digit  = new_rx_data && (state == COLLECT) &&
                    (rx_data == 8'h30 || rx_data == 8'h31);
        is_bksp   = new_rx_data && (state == COLLECT) &&
                    (rx_data == 8'h08) && (count != '0);
        word_done = is_digit && (count == LAST_DIGIT);
    end

    // Shadow word with the incoming digit merged in at position count.
    always_comb begin
        shadow_full = shadow;
        for (int i = 0; i < WIDTH; i++) begin
            if (count == CW'(i)) shadow_full[i] = rx_data[0];
        end
    end

    always_comb begin
        digit_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == CW'(i)) digit_bit = mode_rev ? word_q[WIDTH-1-i] : word_q[i];
        end
        if (idx < CR_IDX)       char_byte = {7'b0011000, digit_bit};
        else if (idx == CR_IDX) char_byte = 8'h0D;
        else                    char_byte = 8'h0A;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (word_done) state_next = SEND;
            SEND:    if (!tx_busy) state_next = GAP;
            GAP:     state_next = (idx == LAST_IDX) ? COLLECT : SEND;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            idx         <= '0;
            shadow      <= '0;
            word_q      <= '0;
            word_valid  <= 1'b0;
            new_tx_data <= 1'b0;
            tx_data     <= 8'h00;
            mode_rev    <= 1'b0;
`ifdef BIT_STRING_ECHO_EN
            echo_pend   <= 1'b0;
            echo_char   <= 8'h00;
            echo_gap    <= 1'b0;
`endif
        end else begin
            word_valid  <= 1'b0;
            new_tx_data <= 1'b0;
            case (state)
                COLLECT: begin
                    if (is_digit) begin
                        shadow <= shadow_full;
                        if (word_done) begin
                            word_q     <= shadow_full;
                            word_valid <= 1'b1;
                            count      <= '0;
                            mode_rev   <= rev_mode;
                            idx        <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (is_bksp) begin
                        count <= count - 1'b1;
                    end
`ifdef BIT_STRING_ECHO_EN
                    // One idle cycle after each echo lets tx_busy rise before the next send.
                    echo_gap <= 1'b0;
                    if (echo_pend && !tx_busy && !echo_gap) begin
                        tx_data     <= echo_char;
                        new_tx_data <= 1'b1;
                        echo_pend   <= 1'b0;
                        echo_gap    <= 1'b1;
                    end
                    if (word_done) begin
                        echo_pend <= 1'b0;
                    end else if (is_digit || is_bksp) begin
                        echo_pend <= 1'b1;
                        echo_char <= rx_data;
                    end
`endif
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data     <= char_byte;
                        new_tx_data <= 1'b1;
                    end
`ifdef BIT_STRING_ECHO_EN
                    echo_pend <= 1'b0;
                    echo_gap  <= 1'b0;
`endif
                end
                GAP: begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
`ifdef BIT_STRING_ECHO_EN
                    echo_pend <= 1'b0;
                    echo_gap  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == SEND) || (state == GAP);
    assign dbg_state = state;
endmodule

// File: tb/tb_bit_string_printer.sv
// Directed bench for bit_string_printer (WIDTH=8, CR LF on) against a digit-list model of the typed text.
module tb_bit_string_printer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         new_rx_data;
    logic         tx_busy;
    logic         rev_mode;
    logic [7:0]   tx_data;
    logic         new_tx_data;
    logic [W-1:0] word_q;
    logic         word_valid;
    logic         busy;
    logic [1:0]   dbg_state;

    bit_string_printer #(.WIDTH(W), .TERM_CRLF(1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_busy(tx_busy), .rev_mode(rev_mode), .tx_data(tx_data),
        .new_tx_data(new_tx_data), .word_q(word_q), .word_valid(word_valid),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0]   exp_tx[$];
    logic [W-1:0] exp_q[$];
    logic [7:0]   cap[$];
    int           digits[$];
    int           strobe_cnt = 0;
    logic         prev_strobe = 1'b0;
    logic         prev_busy = 1'b0;
    logic         force_busy = 1'b0;
    int           busy_cnt = 0;

    assign tx_busy = force_busy || (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Compare process plus tx_busy model (busy for 10 cycles after each strobe).
    always @(negedge clk) begin
        if (!rst) begin
            if (new_tx_data) begin
                strobe_cnt++;
                cap.push_back(tx_data);
                check("no_back_to_back", prev_strobe, 0);
                check("not_while_busy", prev_busy, 0);
                if (exp_tx.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_strobe: got %02h, none expected", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
            if (word_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word_valid: got word %02h, none expected", word_q);
                end else begin
                    check("word_q_on_valid", word_q, exp_q.pop_front());
                end
            end
        end
        prev_strobe = new_tx_data && !rst;
        if (new_tx_data) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        prev_busy = force_busy || (busy_cnt != 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: the typed digit list; a complete word yields its value and its printed characters.
    task automatic model_byte(input logic [7:0] b);
        logic [W-1:0] w;
        if (b == "0" || b == "1") begin
            digits.push_back(int'(b - 8'h30));
            if (digits.size() == W) begin
                w = '0;
                for (int k = 0; k < W; k++) w = w + (W'(digits[k]) << k);
                exp_q.push_back(w);
                for (int k = 0; k < W; k++)
                    exp_tx.push_back(8'h30 + 8'(rev_mode ? digits[W-1-k] : digits[k]));
                exp_tx.push_back(8'h0D);
                exp_tx.push_back(8'h0A);
                digits.delete();
            end
        end else if (b == 8'h08 && digits.size() > 0) begin
            void'(digits.pop_back());
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit model_en);
        rx_data = b;
        new_rx_data = 1'b1;
        if (model_en) model_byte(b);
        tick(1);
        new_rx_data = 1'b0;
        rx_data = 8'h00;
        tick(1);
    endtask

    task automatic type_str(input string s, input bit model_en);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], model_en);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_tx.size() != 0 || busy) && t < 3000) begin
            tick(1);
            t++;
        end
        check(name, t < 3000, 1);
        tick(3);
    endtask

    task automatic wait_strobes(input int target, input string name);
        int t = 0;
        while (strobe_cnt < target && t < 2000) begin
            tick(1);
            t++;
        end
        check(name, strobe_cnt >= target, 1);
    endtask

    task automatic check_cap(input string s);
        logic [7:0] e;
        logic [7:0] a;
        check("cap_len", cap.size(), s.len() + 2);
        for (int i = 0; i < s.len() + 2; i++) begin
            if (i < s.len())       e = s[i];
            else if (i == s.len()) e = 8'h0D;
            else                   e = 8'h0A;
            a = (i < cap.size()) ? cap[i] : 8'hEE;
            check("cap_char", a, e);
        end
        cap.delete();
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        rx_data = 8'h00;
        new_rx_data = 1'b0;
        rev_mode = 1'b0;
        tick(3);
        check("rst_word_q", word_q, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_new_tx_data", new_tx_data, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // Forward print
        type_str("10110000", 1);
        wait_idle("fwd_done");
        check("fwd_word_q", word_q, 8'h0D);
        check_cap("10110000");

        // Reversed print
        rev_mode = 1'b1;
        type_str("10110000", 1);
        wait_idle("rev_done");
        check("rev_word_q", word_q, 8'h0D);
        check_cap("00001101");
        rev_mode = 1'b0;

        // Backspace and ignored bytes
        send_byte("1", 1);
        send_byte("1", 1);
        send_byte(8'h08, 1);
        send_byte("x", 1);
        send_byte("0", 1);
        send_byte(8'h41, 1);
        type_str("000000", 1);
        wait_idle("bksp_done");
        check("bksp_word_q", word_q, 8'h01);
        check_cap("10000000");

        // Backspace with nothing collected
        send_byte(8'h08, 1);
        type_str("01010101", 1);
        wait_idle("bksp0_done");
        check("bksp0_word_q", word_q, 8'hAA);
        check_cap("01010101");

        // Reset in the middle of a print
        s0 = strobe_cnt;
        type_str("11001010", 1);
        wait_strobes(s0 + 4, "mid_reset_reach");
        rst = 1'b1;
        exp_tx.delete();
        exp_q.delete();
        digits.delete();
        tick(2);
        rst = 1'b0;
        check("post_rst_word_q", word_q, 0);
        check("post_rst_busy", busy, 0);
        s0 = strobe_cnt;
        tick(40);
        check("post_rst_no_strobe", strobe_cnt, s0);
        cap.delete();
        type_str("11110000", 1);
        wait_idle("post_rst_done");
        check("post_rst_word", word_q, 8'h0F);
        check_cap("11110000");

        // tx_busy held high while a word is ready to print
        force_busy = 1'b1;
        s0 = strobe_cnt;
        type_str("00000001", 1);
        tick(100);
        check("held_busy_no_strobe", strobe_cnt, s0);
        check("held_busy_state", busy, 1);
        force_busy = 1'b0;
        wait_idle("held_busy_done");
        check("held_busy_word", word_q, 8'h80);
        check_cap("00000001");

        // Digits typed during a print are dropped
        s0 = strobe_cnt;
        type_str("01100000", 1);
        wait_strobes(s0 + 2, "drop_reach");
        type_str("1111", 0);
        wait_idle("drop_done");
        check("drop_word", word_q, 8'h06);
        check_cap("01100000");
        type_str("10000000", 1);
        wait_idle("after_drop_done");
        check("after_drop_word", word_q, 8'h01);
        check_cap("10000000");

        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
